cfg_bus_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for the shared configuration bus (C_valid/C_addr/C_data with C_rdy back-pressure) that drives VGA_Control and the other configurable peripherals.
- Accepts write requests from N_REQ masters (boot sequencer, UART command parser, keypad handler).
- Issues each write as a single-cycle C_valid pulse, then waits for the slave to finish reloading (C_rdy high) before acknowledging the requester.
- A stuck slave is bounded by a timeout.

---
 rtl/cfg_bus_arbiter.sv | 146 ++++++++++++++
 tb/tb_cfg_bus_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_bus_arbiter.sv
// rtl/cfg_bus_arbiter.sv - round-robin write arbiter for the shared configuration bus
module cfg_bus_arbiter #(
  parameter int CONFIG_WIDTH   = 2,
  parameter int N_REQ          = 3,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                            Clk,
  input  logic                            Rst,
  input  logic [N_REQ-1:0]                Req,
  input  logic [N_REQ*CONFIG_WIDTH-1:0]   Req_addr,
  input  logic [N_REQ*CONFIG_WIDTH-1:0]   Req_data,
  output logic [N_REQ-1:0]                Done,
  output logic                            C_valid,
  output logic [CONFIG_WIDTH-1:0]         C_addr,
  output logic [CONFIG_WIDTH-1:0]         C_data,
  input  logic                            C_rdy,
  output logic                            Busy,
  output logic                            Timeout_err
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SW = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, WAIT_RDY} state_t;

  state_t                  state, state_d;
  logic [7:0]              count, count_d;
  logic [PW-1:0]           rr_ptr, rr_ptr_d;
  logic [PW-1:0]           winner, winner_d;
  logic [N_REQ-1:0]        qreq;
  logic [N_REQ-1:0]        done_d;
  logic                    valid_d, busy_d, err_d;
  logic [CONFIG_WIDTH-1:0] addr_d, data_d;
  logic [CONFIG_WIDTH-1:0] sel_addr, sel_data;
  logic                    pick_found;
  logic [PW-1:0]           pick_idx;
  logic [SW-1:0]           sum;
  logic [PW-1:0]           cand;

  // A requester still holding Req during its own Done cycle must not be re-granted.
  assign qreq = Req & ~Done;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    sum        = '0;
    cand       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, rr_ptr} + SW'(k);
      if (sum >= SW'(N_REQ)) sum = sum - SW'(N_REQ);
      cand = sum[PW-1:0];
      if (!pick_found && qreq[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == PW'(i)) begin
        sel_addr = Req_addr[i*CONFIG_WIDTH +: CONFIG_WIDTH];
        sel_data = Req_data[i*CONFIG_WIDTH +: CONFIG_WIDTH];
      end
    end
  end

  always_comb begin
    state_d  = state;
    count_d  = count;
    rr_ptr_d = rr_ptr;
    winner_d = winner;
    done_d   = '0;
    valid_d  = 1'b0;
    addr_d   = C_addr;
    data_d   = C_data;
    err_d    = Timeout_err;
    case (state)
      IDLE: begin
        if (C_rdy && pick_found) begin
          winner_d = pick_idx;
          addr_d   = sel_addr;
          data_d   = sel_data;
          valid_d  = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        count_d = '0;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (count == 8'(SETTLE_CYCLES - 1)) begin
          count_d = '0;
          state_d = WAIT_RDY;
        end else begin
          count_d = count + 8'd1;
        end
      end
      WAIT_RDY: begin
        // A timeout completes the transaction like a normal handshake, but flags it.
        if (C_rdy || count == 8'(TIMEOUT_CYCLES - 1)) begin
          done_d[winner] = 1'b1;
          rr_ptr_d       = (winner == PW'(N_REQ - 1)) ? '0 : winner + 1'b1;
          count_d        = '0;
          state_d        = IDLE;
          if (!C_rdy) err_d = 1'b1;
        end else begin
          count_d = count + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state       <= IDLE;
      count       <= '0;
      rr_ptr      <= '0;
      winner      <= '0;
      Done        <= '0;
      C_valid     <= 1'b0;
      C_addr      <= '0;
      C_data      <= '0;
      Busy        <= 1'b0;
      Timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      count       <= count_d;
      rr_ptr      <= rr_ptr_d;
      winner      <= winner_d;
      Done        <= done_d;
      C_valid     <= valid_d;
      C_addr      <= addr_d;
      C_data      <= data_d;
      Busy        <= busy_d;
      Timeout_err <= err_d;
    end
  end

endmodule

// File: tb/tb_cfg_bus_arbiter.sv
// tb/tb_cfg_bus_arbiter.sv - self-checking bench for cfg_bus_arbiter
module tb_cfg_bus_arbiter;

  localparam int W = 2;
  localparam int N = 3;
  localparam int S = 2;
  localparam int T = 16;

  logic         Clk = 1'b0;
  logic         Rst;
  logic [N-1:0] Req;
  logic [N*W-1:0] Req_addr, Req_data;
  logic [N-1:0] Done;
  logic         C_valid;
  logic [W-1:0] C_addr, C_data;
  logic         C_rdy;
  logic         Busy;
  logic         Timeout_err;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  cfg_bus_arbiter #(.CONFIG_WIDTH(W), .N_REQ(N), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .Clk(Clk), .Rst(Rst), .Req(Req), .Req_addr(Req_addr), .Req_data(Req_data),
    .Done(Done), .C_valid(C_valid), .C_addr(C_addr), .C_data(C_data),
    .C_rdy(C_rdy), .Busy(Busy), .Timeout_err(Timeout_err)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Transaction-level model: a write is granted, then completes on the first
  // ready edge once the settle window has passed, or at the timeout edge.
  logic         m_active = 1'b0;
  logic         m_valid  = 1'b0;
  logic [N-1:0] m_done   = '0;
  logic [W-1:0] m_addr   = '0;
  logic [W-1:0] m_data   = '0;
  logic         m_err    = 1'b0;
  int           m_rr     = 0;
  int           m_win    = 0;
  int           m_age    = 0;

  function automatic int pick(input logic [N-1:0] q, input int rr);
    for (int k = 0; k < N; k++) begin
      if (q[(rr + k) % N]) return (rr + k) % N;
    end
    return 0;
  endfunction

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      m_active <= 1'b0; m_valid <= 1'b0; m_done <= '0; m_addr <= '0; m_data <= '0;
      m_err <= 1'b0; m_rr <= 0; m_win <= 0; m_age <= 0;
    end else begin
      m_valid <= 1'b0;
      m_done  <= '0;
      if (!m_active) begin
        if (C_rdy && (Req & ~m_done) != '0) begin
          m_win    <= pick(Req & ~m_done, m_rr);
          m_addr   <= W'(Req_addr >> (W * pick(Req & ~m_done, m_rr)));
          m_data   <= W'(Req_data >> (W * pick(Req & ~m_done, m_rr)));
          m_valid  <= 1'b1;
          m_active <= 1'b1;
          m_age    <= 0;
        end
      end else begin
        m_age <= m_age + 1;
        if (m_age + 1 >= S + 2 && (C_rdy || m_age + 1 == S + 1 + T)) begin
          m_done   <= N'(1 << m_win);
          m_rr     <= (m_win + 1) % N;
          m_active <= 1'b0;
          if (!C_rdy) m_err <= 1'b1;
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    check("model_outputs", 32'({Done, C_valid, C_addr, C_data, Busy, Timeout_err}),
          32'({m_done, m_valid, m_addr, m_data, m_active, m_err}));
    #1;
  endtask

  task automatic wait_valid(output int at);
    at = -1;
    for (int b = 0; b < 60; b++) begin
      tick();
      if (C_valid) begin at = cyc; return; end
    end
    n_chk++; n_fail++;
    $display("FAIL wait_valid_timeout cyc=%0d got=no C_valid expected=C_valid", cyc);
  endtask

  task automatic wait_done(output int who, output int at);
    who = -1; at = -1;
    for (int b = 0; b < 60; b++) begin
      tick();
      if (Done != '0) begin
        for (int i = 0; i < N; i++) if (Done[i]) who = i;
        at = cyc;
        return;
      end
    end
    n_chk++; n_fail++;
    $display("FAIL wait_done_timeout cyc=%0d got=no Done expected=Done", cyc);
  endtask

  initial begin
    int who, at, tv, t0, prev;
    Rst = 1'b0; Req = 3'b111; C_rdy = 1'b1;
    Req_addr = 6'b11_10_01;
    Req_data = 6'b10_01_11;

    // reset held with all requests pending
    repeat (3) tick();
    check("rst_outputs", 32'({Done, C_valid, C_addr, C_data, Busy, Timeout_err}), 0);
    Rst = 1'b1;
    tick();
    check("rst_grant_valid", C_valid, 1);
    check("rst_grant_addr", C_addr, 2'b01);
    tick();
    check("rst_valid_one_cycle", C_valid, 0);
    wait_done(who, at);
    check("rst_first_winner", who, 0);
    Req = '0;
    repeat (2) tick();

    // single write with ready slave
    Req = 3'b010;
    wait_valid(tv);
    check("sw_addr", C_addr, 2'b10);
    check("sw_data", C_data, 2'b01);
    check("sw_busy", Busy, 1);
    wait_done(who, at);
    check("sw_who", who, 1);
    check("sw_latency", at - tv, 4);
    Req = '0;
    tick();

    // slave reload handshake
    Req = 3'b001;
    wait_valid(tv);
    tick();
    C_rdy = 1'b0;
    repeat (5) tick();
    C_rdy = 1'b1;
    wait_done(who, at);
    check("vga_who", who, 0);
    check("vga_latency", at - tv, 7);
    check("vga_no_timeout", Timeout_err, 0);
    Req = '0;
    tick();

    // round-robin from a fresh pointer
    Rst = 1'b0;
    tick();
    Rst = 1'b1; Req = 3'b111;
    prev = -1;
    for (int i = 0; i < 6; i++) begin
      wait_done(who, at);
      check("rr_order", who, i % 3);
      if (i > 0) check("rr_no_repeat", who == prev, 0);
      prev = who;
      if (i == 5) begin
        Req = '0;
      end else begin
        Req[who] = 1'b0;
        tick();
        Req[who] = 1'b1;
      end
    end
    tick();

    // stuck slave
    Req = 3'b001;
    wait_valid(tv);
    C_rdy = 1'b0;
    wait_done(who, at);
    check("to_latency", at - tv, 19);
    check("to_err_set", Timeout_err, 1);
    Req = '0; C_rdy = 1'b1;
    tick();
    Req = 3'b010;
    wait_done(who, at);
    check("to_err_sticky", Timeout_err, 1);
    Req = '0;
    tick();

    // idle back-pressure
    C_rdy = 1'b0; Req = 3'b100;
    repeat (4) begin
      tick();
      check("bp_no_valid", C_valid, 0);
    end
    t0 = cyc;
    C_rdy = 1'b1;
    wait_valid(tv);
    check("bp_grant_edge", tv - t0, 1);
    check("bp_addr", C_addr, 2'b11);

    // reset during settle
    repeat (2) tick();
    Rst = 1'b0;
    #1;
    check("mid_rst_outputs", 32'({Done, C_valid, Busy, Timeout_err}), 0);
    repeat (2) tick();
    Rst = 1'b1;
    wait_valid(tv);
    check("mid_rst_regrant_addr", C_addr, 2'b11);
    check("mid_rst_regrant_data", C_data, 2'b10);
    wait_done(who, at);
    check("mid_rst_who", who, 2);
    check("mid_rst_latency", at - tv, 4);
    Req = '0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
